// File: rtl/dmem_pkg.sv
// Shared types, address map and lane helpers for the byte-addressed data memory / I/O LSU.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_UNMAPPED = 2'b10,
    ERR_SIZE     = 2'b11
  } err_e;

  localparam int unsigned ADDR_LEDR = 32'h7000;
  localparam int unsigned ADDR_LEDG = 32'h7010;
  localparam int unsigned ADDR_HEX  = 32'h7020;
  localparam int unsigned ADDR_LCD  = 32'h7030;
  localparam int unsigned ADDR_SW   = 32'h7800;

  function automatic logic [3:0] be_gen(size_e size, logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << addr_lo;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] ld_extend(logic [31:0] word, size_e size,
                                            logic [1:0] addr_lo, logic uns);
    logic [31:0] sh;
    sh = word >> {addr_lo, 3'b000};
    case (size)
      SZ_B:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    return sh;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM with per-byte write enables and registered read data.
module dmem_bank #(
  parameter int unsigned WORD_AW = 9
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [3:0]         be_i,
  input  logic [WORD_AW-1:0] addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem [2**WORD_AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed load/store unit: data RAM plus memory-mapped board I/O, one request per cycle,
// response one cycle later.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DMEM_AW     = 11,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   ld_data_o,
  output logic [1:0]        err_o,
  input  logic [XLEN-1:0]   io_sw_i,
  output logic [XLEN-1:0]   io_ledr_o,
  output logic [XLEN-1:0]   io_ledg_o,
  output logic [XLEN-1:0]   io_hex_o,
  output logic [XLEN-1:0]   io_lcd_o
);

  if (XLEN != 32 || DMEM_AW > 12 || DMEM_AW >= ADDR_W || SYNC_STAGES < 1) begin : g_param_check
    $error("dmem_lsu: XLEN must be 32, DMEM_AW <= 12 and < ADDR_W, SYNC_STAGES >= 1");
  end

  localparam logic [ADDR_W-3:0] WA_LEDR = (ADDR_W-2)'(ADDR_LEDR >> 2);
  localparam logic [ADDR_W-3:0] WA_LEDG = (ADDR_W-2)'(ADDR_LEDG >> 2);
  localparam logic [ADDR_W-3:0] WA_HEX  = (ADDR_W-2)'(ADDR_HEX >> 2);
  localparam logic [ADDR_W-3:0] WA_LCD  = (ADDR_W-2)'(ADDR_LCD >> 2);
  localparam logic [ADDR_W-3:0] WA_SW   = (ADDR_W-2)'(ADDR_SW >> 2);

  size_e             req_size;
  logic [1:0]        addr_lo;
  logic [ADDR_W-3:0] word_addr;
  logic              is_dmem, hit_ledr, hit_ledg, hit_hex, hit_lcd, hit_sw, hit_io;
  logic              misaligned, unmapped;
  err_e              err_d;
  logic              req_ok;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata, wmask, io_rdata;

  assign req_size  = size_e'(req_size_i);
  assign addr_lo   = addr_i[1:0];
  assign word_addr = addr_i[ADDR_W-1:2];

  assign is_dmem  = (addr_i[ADDR_W-1:DMEM_AW] == '0);
  assign hit_ledr = (word_addr == WA_LEDR);
  assign hit_ledg = (word_addr == WA_LEDG);
  assign hit_hex  = (word_addr == WA_HEX);
  assign hit_lcd  = (word_addr == WA_LCD);
  assign hit_sw   = (word_addr == WA_SW);
  assign hit_io   = hit_ledr | hit_ledg | hit_hex | hit_lcd | hit_sw;

  assign misaligned = ((req_size == SZ_H) && addr_lo[0]) ||
                      ((req_size == SZ_W) && (addr_lo != 2'b00));
  // Switches are read-only, so a store there reports as unmapped.
  assign unmapped   = !(is_dmem || hit_io) || (req_we_i && hit_sw);

  always_comb begin
    err_d = ERR_OK;
    if (req_size == SZ_X)  err_d = ERR_SIZE;
    else if (misaligned)   err_d = ERR_MISALIGN;
    else if (unmapped)     err_d = ERR_UNMAPPED;
  end

  // A request in the reset cycle is dropped entirely, including its write side effects.
  assign req_ok = rst_ni && req_valid_i && (err_d == ERR_OK);
  assign be     = be_gen(req_size, addr_lo);

  always_comb begin
    wdata = st_data_i;
    case (req_size)
      SZ_B:    wdata = {4{st_data_i[7:0]}};
      SZ_H:    wdata = {2{st_data_i[15:0]}};
      default: wdata = st_data_i;
    endcase
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{be[i]}};
    end
  end

  logic [31:0] ram_rdata;

  dmem_bank #(
    .WORD_AW(DMEM_AW - 2)
  ) u_bank (
    .clk_i  (clk_i),
    .en_i   (req_ok && is_dmem),
    .be_i   (req_we_i ? be : 4'b0000),
    .addr_i (addr_i[DMEM_AW-1:2]),
    .wdata_i(wdata),
    .rdata_o(ram_rdata)
  );

  logic [XLEN-1:0] sw_sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= io_sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  logic [XLEN-1:0] ledr_q, ledg_q, hex_q, lcd_q;
  logic            io_we;

  assign io_we = req_ok && req_we_i && hit_io;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
      lcd_q  <= '0;
    end else if (io_we) begin
      if (hit_ledr) ledr_q <= (ledr_q & ~wmask) | (wdata & wmask);
      if (hit_ledg) ledg_q <= (ledg_q & ~wmask) | (wdata & wmask);
      if (hit_hex)  hex_q  <= (hex_q & ~wmask) | (wdata & wmask);
      if (hit_lcd)  lcd_q  <= (lcd_q & ~wmask) | (wdata & wmask);
    end
  end

  always_comb begin
    io_rdata = '0;
    if (hit_ledr)      io_rdata = ledr_q;
    else if (hit_ledg) io_rdata = ledg_q;
    else if (hit_hex)  io_rdata = hex_q;
    else if (hit_lcd)  io_rdata = lcd_q;
    else if (hit_sw)   io_rdata = sw_sync_q[SYNC_STAGES-1];
  end

  logic            rsp_valid_q, ld_q, src_io_q, uns_q;
  err_e            err_q;
  size_e           size_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] io_rdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      err_q       <= ERR_OK;
      ld_q        <= 1'b0;
      src_io_q    <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      addr_lo_q   <= 2'b00;
      io_rdata_q  <= '0;
    end else begin
      rsp_valid_q <= req_valid_i;
      err_q       <= req_valid_i ? err_d : ERR_OK;
      ld_q        <= req_ok && !req_we_i;
      src_io_q    <= !is_dmem;
      uns_q       <= req_unsigned_i;
      size_q      <= req_size;
      addr_lo_q   <= addr_lo;
      io_rdata_q  <= io_rdata;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign err_o       = err_q;
  assign ld_data_o   = ld_q ? ld_extend(src_io_q ? io_rdata_q : ram_rdata, size_q, addr_lo_q, uns_q)
                            : '0;
  assign io_ledr_o   = ledr_q;
  assign io_ledg_o   = ledg_q;
  assign io_hex_o    = hex_q;
  assign io_lcd_o    = lcd_q;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the word-only DMEM: a byte-addressed load/store unit for the RV32I single-cycle/pipelined core.
- Supports byte, half and word access with sign/zero extension, byte-enable stores and misalignment detection.
- Memory-maps the board I/O (switches, red/green LEDs, HEX, LCD) alongside data RAM.
- Sits between the core's execute/memory stage and the FPGA pins. It is fully pipelined: one request per cycle, response one cycle later.

Parameters:
- XLEN, 32, data width; fixed at 32 for byte-lane logic, checked by an elaboration assertion.
- ADDR_W, 16, byte-address width of addr_i.
- DMEM_AW, 11, log2 of DMEM size in bytes; the RAM holds 2^(DMEM_AW-2) words. Must be ≤ 12.
- SYNC_STAGES, 2, synchroniser depth for io_sw_i.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- req_valid_i  in  1  request strobe
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  1 = zero-extend load (LBU/LHU)
- addr_i  in  ADDR_W  byte address
- st_data_i  in  XLEN  store data, right-aligned
- rsp_valid_o  out  1  response strobe, one cycle after the request
- ld_data_o  out  XLEN  load result, extended
- err_o  out  2  00 ok, 01 misaligned, 10 unmapped, 11 illegal size
- io_sw_i  in  XLEN  switches, asynchronous
- io_ledr_o  out  XLEN  red LEDs
- io_ledg_o  out  XLEN  green LEDs
- io_hex_o  out  XLEN  7-segment
- io_lcd_o  out  XLEN  LCD

Behaviour:
- Reset is synchronous, active-low, on clk_i. While rst_ni=0 at a rising edge:
  - rsp_valid_o, ld_data_o, err_o and all io_*_o registers go to 0.
  - The synchroniser flops clear.
  - RAM contents are not cleared.
  - A request presented in the reset cycle is dropped and produces no response.
- Address map, decoded on the full addr_i:
  - 0x0000 .. 2^DMEM_AW-1: DMEM.
  - 0x7000: LEDR (R/W).
  - 0x7010: LEDG (R/W).
  - 0x7020: HEX (R/W).
  - 0x7030: LCD (R/W).
  - 0x7800: SW (read-only; stores are ignored with err=10).
  - Anything else is unmapped.
  - I/O registers decode only addr_i[ADDR_W-1:2]. Sub-word I/O access uses the same lane rules as DMEM.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always aligned.
- Request acceptance: there is no backpressure; every cycle with req_valid_i=1 is accepted.
- Store:
  - Byte enables are generated from size and addr[1:0]: byte = 1<<addr[1:0], half = 0011<<addr[1:0], word = 1111.
  - Data is replicated to lanes: byte as {4{b}}, half as {2{h}}.
  - Enabled lanes are written at the accepting edge.
  - Next cycle: rsp_valid_o=1, ld_data_o=0, err_o=00.
- Load:
  - The RAM read is synchronous: the address is registered at the accepting edge.
  - The lane is selected by the registered addr[1:0]. The result is sign-extended unless req_unsigned_i was 1.
  - Next cycle: rsp_valid_o=1 with ld_data_o valid.
- Errors (misaligned, unmapped, illegal size):
  - No RAM or I/O state changes.
  - Next cycle: rsp_valid_o=1, ld_data_o=0, err_o set.
  - Priority: illegal size > misaligned > unmapped.
- Back-to-back hazards:
  - A store then a load to the same word on the next cycle returns the new data, because the write commits before the read edge. No forwarding is needed.
  - Same-cycle read/write cannot occur (single port).
- Switch input:
  - io_sw_i passes through a SYNC_STAGES flop chain.
  - An SW load returns the synchronised value sampled at the accepting edge.
  - A change on io_sw_i is visible to a load issued SYNC_STAGES cycles later.
- Idle cycle (req_valid_i=0): next cycle rsp_valid_o=0. ld_data_o and err_o hold 0.
- Reset mid-stream: the response of a request accepted in the cycle before reset assertion is suppressed. rsp_valid_o stays 0 in the cycle after the reset edge.

Decomposition:
- Package dmem_pkg holds:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_X).
  - err_e enum.
  - Address-map localparams: ADDR_LEDR, ADDR_LEDG, ADDR_HEX, ADDR_LCD, ADDR_SW.
  - Function be_gen(size, addr_lo) returning a 4-bit byte-enable mask.
  - Function ld_extend(word, size, addr_lo, uns).
- Sub-module dmem_bank: a single-port synchronous RAM with 4 byte-write enables, depth 2^(DMEM_AW-2), registered read data, no reset on contents.

Test Plan:
- SW 0x12345678 @0x0010, then LW @0x0010 → next cycle rsp_valid=1, ld_data=0x12345678, err=00.
- SB 0xAB @0x0013 over that word, then LB @0x0013 → 0xFFFFFFAB. LBU @0x0013 → 0x000000AB. LW @0x0010 → 0xAB345678.
- LH @0x0011 → err=01, ld_data=0. SW @0x0012 → err=01, and the word at 0x0010 is unchanged.
- SW 0x0000_00FF @0x7000 → io_ledr_o=0xFF one cycle later. LW @0x7000 → 0xFF. SW @0x7800 → err=10, no change. LW @0x4000 → err=10.
- Drive io_sw_i=0xA5, then LW @0x7800 at cycles 0,1,2 → 0,0,0xA5 (SYNC_STAGES=2, switches previously 0).
- Issue LW with rst_ni=0 on the following edge → rsp_valid stays 0 and all io_*_o read 0. After reset is released, RAM data written earlier is still readable.
